// File: rtl/conv_study_pkg.sv
// Shared types and dimensions for the single-image conv pipeline (FWFT -> conv -> max_pool -> post).
// Derived frame sizes come from helper functions so that parameterised blocks compute them the same way.
package conv_study_pkg;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} sched_state_t;

   function automatic int n_in(input int w, input int h);
      return w * h;
   endfunction

   function automatic int n_conv(input int w, input int h, input int k);
      return (w - k + 1) * (h - k + 1);
   endfunction

   function automatic int n_pool(input int w, input int h, input int k, input int ch, input int p);
      return ch * n_conv(w, h, k) / (p * p);
   endfunction

   localparam int CFG_IMG_W    = 32;
   localparam int CFG_IMG_H    = 32;
   localparam int CFG_KERNEL   = 5;
   localparam int CFG_CHANNELS = 6;
   localparam int CFG_POOL     = 2;
   localparam int CFG_TIMEOUT  = 4096;

   localparam int N_IN   = n_in(CFG_IMG_W, CFG_IMG_H);
   localparam int N_CONV = n_conv(CFG_IMG_W, CFG_IMG_H, CFG_KERNEL);
   localparam int N_POOL = n_pool(CFG_IMG_W, CFG_IMG_H, CFG_KERNEL, CFG_CHANNELS, CFG_POOL);

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter; advances one step per en, wraps col at W-1.
// Saturates on the final position so the last coordinate stays visible after the frame.
module raster_counter #(
   parameter int W = 32,
   parameter int H = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   output logic [$clog2(H)-1:0] row,
   output logic [$clog2(W)-1:0] col,
   output logic                 last
);

   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);
   localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   assign last = (row_q == ROW_MAX) & (col_q == COL_MAX);
   assign row  = row_q;
   assign col  = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (en & ~last) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/conv_frame_sched.sv
// Frame sequencer: gates exactly one image of FWFT->conv transfers (combinational, 1 px/cycle, stalls on
// either side low), then counts conv/pool outputs until drained or the watchdog fires; no data path.
module conv_frame_sched
   import conv_study_pkg::*;
#(
   parameter int IMG_W        = CFG_IMG_W,
   parameter int IMG_H        = CFG_IMG_H,
   parameter int KERNEL       = CFG_KERNEL,
   parameter int NUM_CHANNELS = CFG_CHANNELS,
   parameter int POOL         = CFG_POOL,
   parameter int TIMEOUT      = CFG_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic                     i_fifo_valid,
   output logic                     o_fifo_rd_en,
   input  logic                     i_conv_ready,
   output logic                     o_conv_valid,
   input  logic                     i_conv_out_valid,
   input  logic                     i_pool_valid,
   output logic                     o_busy,
   output logic                     o_frame_done,
   output logic [$clog2(IMG_H)-1:0] o_row,
   output logic [$clog2(IMG_W)-1:0] o_col,
   output logic                     o_err_overrun,
   output logic                     o_err_timeout
);

   localparam int FR_IN   = n_in(IMG_W, IMG_H);
   localparam int FR_CONV = n_conv(IMG_W, IMG_H, KERNEL);
   localparam int FR_POOL = n_pool(IMG_W, IMG_H, KERNEL, NUM_CHANNELS, POOL);
   localparam int IN_W    = $clog2(FR_IN + 1);
   localparam int CONV_W  = $clog2(FR_CONV + 1);
   localparam int POOL_W  = $clog2(FR_POOL + 1);
   localparam int WD_W    = $clog2(TIMEOUT);

   sched_state_t      state_q, state_d;
   logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
   logic [CONV_W-1:0] conv_cnt_q, conv_cnt_d;
   logic [POOL_W-1:0] pool_cnt_q, pool_cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              ovr_q, ovr_d, to_q, to_d;
   logic              xfer, pix_last, frame_start, counting, conv_take, pool_take;

   assign xfer        = (state_q == FEED) & i_fifo_valid & i_conv_ready & ~rst;
   assign frame_start = (state_q == IDLE) & i_start;
   assign counting    = (state_q == FEED) | (state_q == DRAIN);
   // Anything not taken here is an overrun: outside a frame, or beyond the expected count.
   assign conv_take   = counting & i_conv_out_valid & (conv_cnt_q != CONV_W'(FR_CONV));
   assign pool_take   = counting & i_pool_valid & (pool_cnt_q != POOL_W'(FR_POOL));

   assign o_fifo_rd_en  = xfer;
   assign o_conv_valid  = xfer;
   assign o_busy        = (state_q != IDLE);
   assign o_frame_done  = (state_q == DONE);
   assign o_err_overrun = ovr_q;
   assign o_err_timeout = to_q;

   raster_counter #(.W(IMG_W), .H(IMG_H)) u_raster (
      .clk  (clk),
      .rst  (rst),
      .en   (xfer),
      .clr  (frame_start),
      .row  (o_row),
      .col  (o_col),
      .last (pix_last)
   );

   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      conv_cnt_d = conv_take ? conv_cnt_q + CONV_W'(1) : conv_cnt_q;
      pool_cnt_d = pool_take ? pool_cnt_q + POOL_W'(1) : pool_cnt_q;
      wd_d       = wd_q;
      ovr_d      = ovr_q | (i_conv_out_valid & ~conv_take) | (i_pool_valid & ~pool_take);
      to_d       = to_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d    = FEED;
               in_cnt_d   = '0;
               conv_cnt_d = '0;
               pool_cnt_d = '0;
               wd_d       = '0;
               ovr_d      = 1'b0;
               to_d       = 1'b0;
            end
         end
         FEED: begin
            wd_d = '0;
            if (xfer) begin
               in_cnt_d = in_cnt_q + IN_W'(1);
               if (pix_last & (in_cnt_q == IN_W'(FR_IN - 1))) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // A pool output in the expiry cycle wins over the watchdog.
            if (pool_cnt_d == POOL_W'(FR_POOL)) begin
               state_d = DONE;
            end else if (pool_take) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
               if (wd_q == WD_W'(TIMEOUT - 2)) begin
                  to_d    = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in_cnt_q   <= '0;
         conv_cnt_q <= '0;
         pool_cnt_q <= '0;
         wd_q       <= '0;
         ovr_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         conv_cnt_q <= conv_cnt_d;
         pool_cnt_q <= pool_cnt_d;
         wd_q       <= wd_d;
         ovr_q      <= ovr_d;
         to_q       <= to_d;
      end
   end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Randomised frames against a counting reference model of the frame scheduler.
module tb_conv_frame_sched;

   localparam int W     = 32;
   localparam int H     = 32;
   localparam int K     = 5;
   localparam int CH    = 6;
   localparam int P     = 2;
   localparam int TO    = 16;
   localparam int NIN   = W * H;
   localparam int NCONV = (W - K + 1) * (H - K + 1);
   localparam int NPOOL = CH * NCONV / (P * P);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, fv = 1'b0, cr = 1'b0, cv = 1'b0, pv = 1'b0;
   logic       rd_en, conv_valid, busy, done, err_ovr, err_to;
   logic [4:0] row, col;

   always #5 clk = ~clk;

   conv_frame_sched #(
      .IMG_W(W), .IMG_H(H), .KERNEL(K), .NUM_CHANNELS(CH), .POOL(P), .TIMEOUT(TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (start),
      .i_fifo_valid     (fv),
      .o_fifo_rd_en     (rd_en),
      .i_conv_ready     (cr),
      .o_conv_valid     (conv_valid),
      .i_conv_out_valid (cv),
      .i_pool_valid     (pv),
      .o_busy           (busy),
      .o_frame_done     (done),
      .o_row            (row),
      .o_col            (col),
      .o_err_overrun    (err_ovr),
      .o_err_timeout    (err_to)
   );

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         if (bad <= 20) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: frame active/done flags plus plain event counts.
   bit m_active = 0, m_done = 0, m_ovr = 0, m_to = 0;
   int m_pix = 0, m_conv = 0, m_pool = 0, m_quiet = 0, n_exp_done = 0;
   int cyc = 0, n_xfer = 0, n_done_dut = 0, last_pool_cyc = 0, done_cyc = 0;

   task automatic model_update(input bit s, input bit f, input bit c, input bit cvv, input bit pvv, input bit r);
      bit feeding, counted;
      if (r) begin
         m_active = 0; m_done = 0; m_pix = 0; m_conv = 0; m_pool = 0;
         m_ovr = 0; m_to = 0; m_quiet = 0;
      end else if (!m_active) begin
         if (s) begin
            m_active = 1; m_pix = 0; m_conv = 0; m_pool = 0;
            m_ovr = 0; m_to = 0; m_quiet = 0;
         end else if (cvv || pvv) begin
            m_ovr = 1;
         end
      end else if (m_done) begin
         m_active = 0; m_done = 0;
         if (cvv || pvv) m_ovr = 1;
      end else begin
         feeding = (m_pix < NIN);
         counted = 0;
         if (cvv) begin
            if (m_conv == NCONV) m_ovr = 1; else m_conv++;
         end
         if (pvv) begin
            if (m_pool == NPOOL) m_ovr = 1;
            else begin m_pool++; counted = 1; end
         end
         if (feeding) begin
            if (f && c) m_pix++;
            m_quiet = 0;
         end else if (m_pool == NPOOL) begin
            m_done = 1; n_exp_done++;
         end else if (counted) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == TO - 1) begin m_to = 1; m_done = 1; n_exp_done++; end
         end
      end
   endtask

   task automatic step(input bit s, input bit f, input bit c, input bit cvv, input bit pvv, input bit r);
      bit exp_rd;
      int p;
      start = s; fv = f; cr = c; cv = cvv; pv = pvv; rst = r;
      @(negedge clk);
      exp_rd = !r && m_active && !m_done && (m_pix < NIN) && f && c;
      p = (m_pix < NIN) ? m_pix : NIN - 1;
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      chk("conv_valid", 32'(conv_valid), 32'(exp_rd));
      chk("busy", 32'(busy), 32'(m_active));
      chk("frame_done", 32'(done), 32'(m_done));
      chk("row", 32'(row), p / W);
      chk("col", 32'(col), p % W);
      chk("err_overrun", 32'(err_ovr), 32'(m_ovr));
      chk("err_timeout", 32'(err_to), 32'(m_to));
      if (rd_en === 1'b1) begin
         chk("raster_order", int'(row) * W + int'(col), n_xfer);
         n_xfer++;
      end
      if (done === 1'b1) begin n_done_dut++; done_cyc = cyc; end
      if (pvv) last_pool_cyc = cyc;
      model_update(s, f, c, cvv, pvv, r);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_frame(input int fv_pct, input int cr_pct, input int conv_pct, input int conv_lim,
                            input int pool_pct, input int pool_lim, input int busy_start_pct,
                            input bit start_in_done, input int rst_at);
      int nc = 0, np = 0, budget = 0;
      bit s, f, c, cvv, pvv, r;
      n_xfer = 0;
      step(1, 0, 0, 0, 0, 0);
      while (m_active && budget < 8000) begin
         f   = ($urandom_range(99) < fv_pct);
         c   = ($urandom_range(99) < cr_pct);
         cvv = !m_done && (nc < conv_lim) && ($urandom_range(99) < conv_pct);
         pvv = !m_done && (np < pool_lim) && ($urandom_range(99) < pool_pct);
         if (cvv) nc++;
         if (pvv) np++;
         s = m_done ? start_in_done : ($urandom_range(99) < busy_start_pct);
         r = (rst_at >= 0) && (m_pix == rst_at) && !m_done;
         step(s, f, c, cvv, pvv, r);
         budget++;
      end
      chk("frame_budget", 32'(budget < 8000), 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      step(0, 1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_row", 32'(row), 0);

      // Nominal back-to-back frame.
      run_frame(100, 100, 100, NCONV, 80, NPOOL, 0, 0, -1);
      chk("nom_xfers", n_xfer, NIN);
      chk("nom_done_lat", done_cyc - last_pool_cyc, 1);
      chk("nom_ovr", 32'(err_ovr), 0);
      chk("nom_to", 32'(err_to), 0);
      idle(3);

      // Pool output while idle.
      step(0, 0, 0, 0, 1, 0);
      idle(4);
      chk("idle_pool_ovr", 32'(err_ovr), 1);

      // Backpressure on both sides.
      run_frame(70, 50, 60, NCONV, 80, NPOOL, 0, 0, -1);
      chk("bp_xfers", n_xfer, NIN);
      chk("bp_ovr", 32'(err_ovr), 0);
      idle(2);

      // One conv output too many.
      run_frame(100, 100, 100, NCONV + 1, 80, NPOOL, 0, 0, -1);
      chk("conv_ovr_set", 32'(err_ovr), 1);
      chk("conv_ovr_done_lat", done_cyc - last_pool_cyc, 1);
      idle(5);
      chk("conv_ovr_sticky", 32'(err_ovr), 1);

      // Pool outputs stop early: watchdog ends the frame.
      run_frame(100, 100, 100, NCONV, 80, 1000, 0, 0, -1);
      chk("to_set", 32'(err_to), 1);
      chk("to_done_lat", done_cyc - last_pool_cyc, 16);
      chk("to_no_ovr", 32'(err_ovr), 0);
      idle(2);

      // Reset mid-feed, then a full frame.
      run_frame(100, 100, 100, NCONV, 80, NPOOL, 0, 0, 500);
      chk("rst_mid_xfers", n_xfer, 500);
      rst = 1'b0; fv = 1'b1; cr = 1'b1; start = 1'b0; cv = 1'b0; pv = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_row", 32'(row), 0);
      chk("rst_mid_col", 32'(col), 0);
      chk("rst_mid_rd_en", 32'(rd_en), 0);
      idle(2);
      run_frame(100, 100, 100, NCONV, 80, NPOOL, 0, 0, -1);
      chk("post_rst_xfers", n_xfer, NIN);

      // Starts while busy and in the DONE cycle are ignored.
      idle(2);
      run_frame(90, 90, 100, NCONV, 80, NPOOL, 5, 1, -1);
      chk("busy_start_xfers", n_xfer, NIN);
      idle(3);
      chk("busy_start_idle", 32'(busy), 0);
      chk("done_count", n_done_dut, n_exp_done);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
